// File: rtl/ddr_global_pkg.sv
// Shared types and constants for the DDR output serializer lane logic.
package ddr_global_pkg;

    // Lane operating mode, sampled only while the lane is idle.
    typedef enum logic [1:0] {
        MODE_DATA   = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_PRBS7  = 2'd2,
        MODE_HOLD   = 2'd3
    } ddr_ser_mode_t;

    // Lane sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_POST,
        ST_TGL,
        ST_PRBS
    } ddr_ser_state_t;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    // One Fibonacci step of x^7+x^6+1; the new bit enters at bit 0.
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/ddr_prbs7_2b.sv
// PRBS7 generator producing two new bits per cycle. The bits shown on
// o_bit0/o_bit1 are the two that the next advance commits, so a seed load
// and an advance in the same cycle yield the first two bits after the seed.
module ddr_prbs7_2b
    import ddr_global_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_seed_ld,
    input  logic i_adv,
    output logic o_bit0,
    output logic o_bit1
);

    logic [6:0] lfsr;
    logic [6:0] base;
    logic [6:0] step1;
    logic [6:0] step2;

    // Look two steps ahead from either the seed or the current state.
    always_comb begin
        base   = i_seed_ld ? PRBS7_SEED : lfsr;
        step1  = prbs7_step(base);
        step2  = prbs7_step(step1);
        o_bit0 = step1[0];
        o_bit1 = step2[0];
    end

    // LFSR state: advance by two, or just reload the seed.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (i_rst) begin
            lfsr <= PRBS7_SEED;
        end else if (i_adv) begin
            lfsr <= step2;
        end else if (i_seed_ld) begin
            lfsr <= PRBS7_SEED;
        end
    end

endmodule

// File: rtl/ddr_2to1_lane_sched.sv
// Per-lane sequencer for the 2:1 DDR output serializer. Frames parallel
// words with a toggle preamble and idle postamble, and can emit a toggle
// or PRBS7 training pattern. o_even/o_odd always show the current state's pair.
module ddr_2to1_lane_sched
    import ddr_global_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_idle_val,
    input  logic [CW-1:0]    i_pre_len,
    input  logic [CW-1:0]    i_post_len,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic             o_even,
    output logic             o_odd,
    output logic             o_busy
);

    localparam int NPAIR = WIDTH / 2;
    localparam int IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPAIR - 1);

    ddr_ser_state_t state, state_nxt;
    ddr_ser_mode_t  mode;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [CW:0]      cnt_inc;
    logic [IW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             even_nxt, odd_nxt;
    logic             pre_last, post_last, accept;
    logic             seed_ld, adv, prbs_b0, prbs_b1;

    assign mode      = ddr_ser_mode_t'(i_mode);
    // Wider compare so a length shrinking mid-phase cannot make the count wrap.
    assign cnt_inc   = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign pre_last  = cnt_inc >= {1'b0, i_pre_len};
    assign post_last = cnt_inc >= {1'b0, i_post_len};
    assign accept    = o_data_ready && i_data_valid;

    ddr_prbs7_2b u_prbs (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_seed_ld (seed_ld),
        .i_adv     (adv),
        .o_bit0    (prbs_b0),
        .o_bit1    (prbs_b1)
    );

    // Ready is offered in the cycle whose edge loads pair 0 of the next word.
    always_comb begin
        o_data_ready = 1'b0;
        if (!i_rst) begin
            case (state)
                ST_IDLE: o_data_ready = i_en && (mode == MODE_DATA) && (i_pre_len == '0);
                ST_PRE:  o_data_ready = pre_last;
                ST_DATA: o_data_ready = (idx == LAST_IDX) && i_en;
                default: o_data_ready = 1'b0;
            endcase
        end
    end

    // Next state, counters, shift register and next output pair.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        even_nxt  = i_idle_val;
        odd_nxt   = i_idle_val;
        seed_ld   = 1'b0;
        adv       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_en) begin
                    case (mode)
                        MODE_DATA: begin
                            if (accept) begin
                                state_nxt = ST_DATA;
                            end else if (i_data_valid) begin
                                state_nxt = ST_PRE;
                                cnt_nxt   = '0;
                                even_nxt  = 1'b1;
                                odd_nxt   = 1'b0;
                            end
                        end
                        MODE_TOGGLE: begin
                            state_nxt = ST_TGL;
                            even_nxt  = 1'b1;
                            odd_nxt   = 1'b0;
                        end
                        MODE_PRBS7: begin
                            state_nxt = ST_PRBS;
                            seed_ld   = 1'b1;
                            adv       = 1'b1;
                            even_nxt  = prbs_b0;
                            odd_nxt   = prbs_b1;
                        end
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_PRE: begin
                if (pre_last) begin
                    // A missing word here is a protocol violation; fall back to idle.
                    state_nxt = accept ? ST_DATA : ST_IDLE;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    even_nxt = 1'b1;
                    odd_nxt  = 1'b0;
                end
            end
            ST_DATA: begin
                if (idx != LAST_IDX) begin
                    idx_nxt   = idx + 1'b1;
                    even_nxt  = shreg[0];
                    odd_nxt   = shreg[1];
                    shreg_nxt = {2'b00, shreg[WIDTH-1:2]};
                end else if (!accept) begin
                    state_nxt = (i_post_len != '0) ? ST_POST : ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_POST: begin
                if (post_last) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt + 1'b1;
            end
            ST_TGL: begin
                if (i_en) begin
                    even_nxt = 1'b1;
                    odd_nxt  = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PRBS: begin
                if (i_en) begin
                    adv      = 1'b1;
                    even_nxt = prbs_b0;
                    odd_nxt  = prbs_b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Any accepted word starts a fresh pass through the shift register.
        if (accept) begin
            state_nxt = ST_DATA;
            idx_nxt   = '0;
            even_nxt  = i_data[0];
            odd_nxt   = i_data[1];
            shreg_nxt = {2'b00, i_data[WIDTH-1:2]};
        end
    end

    // State, counters and registered serializer outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            o_even <= 1'b0;
            o_odd  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shreg  <= shreg_nxt;
            o_even <= even_nxt;
            o_odd  <= odd_nxt;
            o_busy <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ddr_2to1_lane_sched.sv
// Directed bench for ddr_2to1_lane_sched (WIDTH=8, CW=4). Each cycle the
// observed {even, odd, busy, ready} is compared against hand-computed values.
module tb_ddr_2to1_lane_sched;

    logic       clk, rst, en, idle_val, valid;
    logic       ready, even, odd, busy;
    logic [1:0] mode;
    logic [3:0] pre_len, post_len;
    logic [7:0] data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int hs_cnt   = 0;
    int hs_first = 0;
    int hs_last  = 0;
    int mism;

    logic [3:0]   obs;
    logic [253:0] prbs_bits;
    logic [6:0]   model;
    logic         b0, b1;

    // {even, odd, busy, ready} per cycle
    logic [3:0] exp_w1  [9]  = '{4'b0000, 4'b1010, 4'b1011, 4'b0010, 4'b1010,
                                 4'b1110, 4'b0111, 4'b0010, 4'b0000};
    logic [3:0] exp_b2b [13] = '{4'b1100, 4'b1011, 4'b1110, 4'b1110, 4'b1110,
                                 4'b1111, 4'b0010, 4'b0010, 4'b0010, 4'b0011,
                                 4'b1110, 4'b1110, 4'b1100};
    logic [3:0] exp_p0  [6]  = '{4'b0001, 4'b0110, 4'b1010, 4'b1010, 4'b0111, 4'b0000};
    logic [3:0] exp_tgl [5]  = '{4'b1100, 4'b1010, 4'b1010, 4'b1010, 4'b1100};
    logic [3:0] exp_abt [7]  = '{4'b1101, 4'b0010, 4'b1010, 4'b1110, 4'b0000,
                                 4'b0000, 4'b1100};

    ddr_2to1_lane_sched #(.WIDTH(8), .CW(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_mode       (mode),
        .i_idle_val   (idle_val),
        .i_pre_len    (pre_len),
        .i_post_len   (post_len),
        .i_data       (data),
        .i_data_valid (valid),
        .o_data_ready (ready),
        .o_even       (even),
        .o_odd        (odd),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Called just after a rising edge with this cycle's inputs applied;
    // samples on the falling edge and returns just after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] exp, output logic [3:0] seen);
        @(negedge clk);
        seen = {even, odd, busy, ready};
        if (ready === 1'b1 && valid === 1'b1) begin
            if (hs_cnt == 0) hs_first = cyc_n;
            hs_last = cyc_n;
            hs_cnt++;
        end
        check(tag, 32'(seen), 32'(exp));
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'd0; valid = 1'b1; data = 8'hFF;
        pre_len = 4'd0; post_len = 4'd0; idle_val = 1'b0;
        tick();

        // Reset dominates a ready-to-accept configuration.
        for (int i = 0; i < 3; i++) cyc($sformatf("reset c%0d", i), 4'b0000, obs);
        rst = 1'b0; valid = 1'b0; en = 1'b0;
        cyc("post-reset idle", 4'b0000, obs);

        // Single word 8'hB4 with pre=2, post=1.
        en = 1'b1; mode = 2'd0; pre_len = 4'd2; post_len = 4'd1;
        idle_val = 1'b0; data = 8'hB4; valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) valid = 1'b0;
            cyc($sformatf("word c%0d", i), exp_w1[i], obs);
        end

        // Back-to-back 8'hFF, 8'h00 with pre=1, post=2, idle level 1.
        idle_val = 1'b1; en = 1'b0;
        tick();
        en = 1'b1; pre_len = 4'd1; post_len = 4'd2; data = 8'hFF; valid = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 2) data = 8'h00;
            if (i == 6) valid = 1'b0;
            cyc($sformatf("b2b c%0d", i), exp_b2b[i], obs);
        end
        check("b2b handshakes", 32'(hs_cnt), 32'd2);
        check("b2b spacing", 32'(hs_last - hs_first), 32'd4);

        // pre=0, post=0: accepted in IDLE, back to IDLE after last pair.
        idle_val = 1'b0; en = 1'b0;
        tick();
        en = 1'b1; pre_len = 4'd0; post_len = 4'd0; data = 8'h96; valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) valid = 1'b0;
            if (i == 5) en = 1'b0;
            cyc($sformatf("pre0 c%0d", i), exp_p0[i], obs);
        end

        // HOLD keeps the lane idle even with a valid word.
        en = 1'b1; mode = 2'd3; valid = 1'b1;
        for (int i = 0; i < 2; i++) cyc($sformatf("hold c%0d", i), 4'b0000, obs);
        valid = 1'b0;

        // TOGGLE; a mode change mid-pattern is ignored; en drop returns to idle.
        idle_val = 1'b1;
        tick();
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) mode = 2'd2;
            if (i == 3) en = 1'b0;
            cyc($sformatf("toggle c%0d", i), exp_tgl[i], obs);
        end

        // PRBS7 for 127 enabled cycles against a reference LFSR.
        idle_val = 1'b0; mode = 2'd2; en = 1'b0;
        tick();
        en = 1'b1;
        cyc("prbs entry", 4'b0000, obs);
        model = 7'h7F;
        for (int k = 0; k < 127; k++) begin
            model = {model[5:0], model[6] ^ model[5]};
            b0    = model[0];
            model = {model[5:0], model[6] ^ model[5]};
            b1    = model[0];
            if (k == 126) en = 1'b0;
            cyc($sformatf("prbs pair %0d", k), {b0, b1, 2'b10}, obs);
            prbs_bits[2*k]   = obs[3];
            prbs_bits[2*k+1] = obs[2];
        end
        cyc("prbs exit", 4'b0000, obs);
        mism = 0;
        for (int i = 0; i < 127; i++) if (prbs_bits[i] !== prbs_bits[i+127]) mism++;
        check("prbs period 127", 32'(mism), 32'd0);

        // Reset at pair 2 drops the word: outputs 0, idle, no ready.
        idle_val = 1'b1; mode = 2'd0; en = 1'b0;
        tick();
        en = 1'b1; pre_len = 4'd0; post_len = 4'd0; data = 8'hB4; valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) valid = 1'b0;
            if (i == 3) rst = 1'b1;
            if (i == 5) begin rst = 1'b0; en = 1'b0; end
            cyc($sformatf("abort c%0d", i), exp_abt[i], obs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
